// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage plus the MEM/WB pipeline register.
// Performs byte/half/word loads and stores on an internal data memory,
// formats load data and registers everything toward write-back.
// Optional debug read port is enabled by defining MEM_WB_DEBUG_PORT_EN.
module mem_wb_stage #(
    parameter int NB_DATA     = 32,
    parameter int NB_REGWR    = 5,
    parameter int NB_PC       = 7,
    parameter int NB_MEM_ADDR = 7
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   en_pipeline,
    input  logic [NB_DATA-1:0]     alu_result_i,
    input  logic [NB_DATA-1:0]     data_wr_to_mem_i,
    input  logic [NB_REGWR-1:0]    writeReg_i,
    input  logic [NB_PC-1:0]       pc_i,
    input  logic [5:0]             mem_signals_i,
    input  logic                   reg_write_i,
`ifdef MEM_WB_DEBUG_PORT_EN
    input  logic [NB_MEM_ADDR-1:0] debug_addr_i,
    output logic [NB_DATA-1:0]     debug_data_o,
`endif
    output logic [NB_DATA-1:0]     mem_data_o,
    output logic [NB_DATA-1:0]     alu_result_o,
    output logic [NB_REGWR-1:0]    writeReg_o,
    output logic [NB_PC-1:0]       pc_o,
    output logic                   mem_to_reg_o,
    output logic                   reg_write_o,
    output logic                   misalign_o
);

    localparam int MEM_DEPTH = 1 << NB_MEM_ADDR;

    // Data memory: one NB_DATA-bit word per entry, never cleared by reset
    logic [NB_DATA-1:0] memArray [MEM_DEPTH];

    // Decoded control fields
    logic                   memRead;
    logic                   memWrite;
    logic [1:0]             accessSize;
    logic                   unsignedLoad;
    logic                   memToReg;
    logic                   isByte;
    logic                   isHalf;
    logic                   isWord;
    logic [1:0]             byteLane;
    logic [NB_MEM_ADDR-1:0] wordIdx;
    logic                   misalignedAddr;
    logic                   misalignAccess;
    logic                   storeEn;

    // Store path
    logic [3:0]             byteEn;
    logic [NB_DATA-1:0]     wrData;

    // Load path
    logic [NB_DATA-1:0]     rdWord;
    logic [NB_DATA-1:0]     rdShifted;
    logic [NB_DATA-1:0]     loadData;

    // MEM/WB register state and next-state
    logic [NB_DATA-1:0]     memData_q,   memData_d;
    logic [NB_DATA-1:0]     aluResult_q, aluResult_d;
    logic [NB_REGWR-1:0]    writeReg_q,  writeReg_d;
    logic [NB_PC-1:0]       pc_q,        pc_d;
    logic                   memToReg_q,  memToReg_d;
    logic                   regWrite_q,  regWrite_d;
    logic                   misalign_q,  misalign_d;

    assign memRead      = mem_signals_i[5];
    assign memWrite     = mem_signals_i[4];
    assign accessSize   = mem_signals_i[3:2];
    assign unsignedLoad = mem_signals_i[1];
    assign memToReg     = mem_signals_i[0];

    // Size 2'b10 is reserved and behaves as a word access
    assign isByte = (accessSize == 2'b00);
    assign isHalf = (accessSize == 2'b01);
    assign isWord = !isByte && !isHalf;

    // Upper address bits are dropped so addresses wrap modulo the memory size
    assign byteLane = alu_result_i[1:0];
    assign wordIdx  = alu_result_i[NB_MEM_ADDR+1:2];

    assign misalignedAddr = (isHalf && byteLane[0]) || (isWord && (byteLane != 2'b00));
    assign misalignAccess = (memRead || memWrite) && misalignedAddr;

    // Gating with reset_i keeps a store from landing on an edge while reset is held
    assign storeEn = en_pipeline && reset_i && memWrite && !misalignedAddr;

    // Build byte enables and lane-replicated store data from size and lane
    always_comb begin
        byteEn = 4'b0000;
        wrData = data_wr_to_mem_i;
        if (isByte) begin
            byteEn = 4'b0001 << byteLane;
            wrData = {4{data_wr_to_mem_i[7:0]}};
        end else if (isHalf) begin
            byteEn = byteLane[1] ? 4'b1100 : 4'b0011;
            wrData = {2{data_wr_to_mem_i[15:0]}};
        end else begin
            byteEn = 4'b1111;
        end
    end

    // Byte-enabled write into the data memory
    always_ff @(posedge clock_i) begin
        if (storeEn) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    memArray[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
                end
            end
        end
    end

    assign rdWord    = memArray[wordIdx];
    assign rdShifted = rdWord >> {byteLane, 3'b000};

`ifdef MEM_WB_DEBUG_PORT_EN
    assign debug_data_o = memArray[debug_addr_i];
`endif

    // Select and extend load lanes; stores, idle and misaligned accesses give 0
    always_comb begin
        loadData = '0;
        if (memRead && !memWrite && !misalignedAddr) begin
            if (isByte) begin
                loadData = unsignedLoad ? {{(NB_DATA-8){1'b0}}, rdShifted[7:0]}
                                        : {{(NB_DATA-8){rdShifted[7]}}, rdShifted[7:0]};
            end else if (isHalf) begin
                loadData = unsignedLoad ? {{(NB_DATA-16){1'b0}}, rdShifted[15:0]}
                                        : {{(NB_DATA-16){rdShifted[15]}}, rdShifted[15:0]};
            end else begin
                loadData = rdWord;
            end
        end
    end

    // Next-state for the MEM/WB register; a stall holds every field
    always_comb begin
        memData_d   = memData_q;
        aluResult_d = aluResult_q;
        writeReg_d  = writeReg_q;
        pc_d        = pc_q;
        memToReg_d  = memToReg_q;
        regWrite_d  = regWrite_q;
        misalign_d  = misalign_q;
        if (en_pipeline) begin
            memData_d   = loadData;
            aluResult_d = alu_result_i;
            writeReg_d  = writeReg_i;
            pc_d        = pc_i;
            memToReg_d  = memToReg;
            regWrite_d  = reg_write_i && !misalignAccess;
            misalign_d  = misalign_q || misalignAccess;
        end
    end

    // MEM/WB register with asynchronous active-low reset
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            memData_q   <= '0;
            aluResult_q <= '0;
            writeReg_q  <= '0;
            pc_q        <= '0;
            memToReg_q  <= 1'b0;
            regWrite_q  <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            memData_q   <= memData_d;
            aluResult_q <= aluResult_d;
            writeReg_q  <= writeReg_d;
            pc_q        <= pc_d;
            memToReg_q  <= memToReg_d;
            regWrite_q  <= regWrite_d;
            misalign_q  <= misalign_d;
        end
    end

    assign mem_data_o   = memData_q;
    assign alu_result_o = aluResult_q;
    assign writeReg_o   = writeReg_q;
    assign pc_o         = pc_q;
    assign mem_to_reg_o = memToReg_q;
    assign reg_write_o  = regWrite_q;
    assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized and directed stimulus for mem_wb_stage,
// checked every cycle against a byte-addressed behavioural model.
module tb_mem_wb_stage;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        en_pipeline = 1'b0;
    logic [31:0] alu_result_i = '0;
    logic [31:0] data_wr_to_mem_i = '0;
    logic [4:0]  writeReg_i = '0;
    logic [6:0]  pc_i = '0;
    logic [5:0]  mem_signals_i = '0;
    logic        reg_write_i = 1'b0;
    logic [31:0] mem_data_o;
    logic [31:0] alu_result_o;
    logic [4:0]  writeReg_o;
    logic [6:0]  pc_o;
    logic        mem_to_reg_o;
    logic        reg_write_o;
    logic        misalign_o;
`ifdef MEM_WB_DEBUG_PORT_EN
    logic [6:0]  debug_addr_i = '0;
    logic [31:0] debug_data_o;
`endif

    int compared = 0;
    int mismatched = 0;
    bit checkEnable = 1'b0;

    mem_wb_stage #(
        .NB_DATA(32), .NB_REGWR(5), .NB_PC(7), .NB_MEM_ADDR(7)
    ) dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .en_pipeline     (en_pipeline),
        .alu_result_i    (alu_result_i),
        .data_wr_to_mem_i(data_wr_to_mem_i),
        .writeReg_i      (writeReg_i),
        .pc_i            (pc_i),
        .mem_signals_i   (mem_signals_i),
        .reg_write_i     (reg_write_i),
`ifdef MEM_WB_DEBUG_PORT_EN
        .debug_addr_i    (debug_addr_i),
        .debug_data_o    (debug_data_o),
`endif
        .mem_data_o      (mem_data_o),
        .alu_result_o    (alu_result_o),
        .writeReg_o      (writeReg_o),
        .pc_o            (pc_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .reg_write_o     (reg_write_o),
        .misalign_o      (misalign_o)
    );

    always #5 clock_i = ~clock_i;

    // Behavioural model: 512 bytes of memory plus the expected registered outputs
    logic [7:0]  modelBytes [512];
    logic [31:0] expMemData = '0;
    logic [31:0] expAlu = '0;
    logic [4:0]  expWriteReg = '0;
    logic [6:0]  expPc = '0;
    logic        expMemToReg = 1'b0;
    logic        expRegWrite = 1'b0;
    logic        expMisalign = 1'b0;
    int unsigned mAddr;
    int unsigned mBytes;
    bit          mRd, mWr, mMis;
    logic [31:0] mVal;

    initial begin
        for (int i = 0; i < 512; i++) modelBytes[i] = 8'h00;
    end

    function automatic logic [31:0] modelLoad(int unsigned a, int unsigned n, bit uns);
        logic [31:0] v = '0;
        for (int k = 0; k < int'(n); k++) v = v | (32'(modelBytes[(a + k) % 512]) << (8 * k));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] modelWord(int unsigned idx);
        return modelLoad(idx * 4, 4, 1'b1);
    endfunction

    // Model update on each rising edge, and cleared by asynchronous reset
    always @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            expMemData  = '0;
            expAlu      = '0;
            expWriteReg = '0;
            expPc       = '0;
            expMemToReg = 1'b0;
            expRegWrite = 1'b0;
            expMisalign = 1'b0;
        end else if (en_pipeline) begin
            mAddr = alu_result_i % 512;
            mRd   = mem_signals_i[5];
            mWr   = mem_signals_i[4];
            case (mem_signals_i[3:2])
                2'b00:   mBytes = 1;
                2'b01:   mBytes = 2;
                default: mBytes = 4;
            endcase
            mMis = (mRd || mWr) && (mAddr % mBytes != 0);
            mVal = modelLoad(mAddr, mBytes, mem_signals_i[1]);
            expMemData = (mRd && !mWr && !mMis) ? mVal : 32'h0;
            if (mWr && !mMis) begin
                for (int k = 0; k < int'(mBytes); k++)
                    modelBytes[mAddr + k] = 8'(data_wr_to_mem_i >> (8 * k));
            end
            expAlu      = alu_result_i;
            expWriteReg = writeReg_i;
            expPc       = pc_i;
            expMemToReg = mem_signals_i[0];
            expRegWrite = reg_write_i && !mMis;
            expMisalign = expMisalign || mMis;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every DUT output against the model on each falling edge
    always @(negedge clock_i) begin
        if (checkEnable) begin
            checkOutput("mem_data_o",   mem_data_o,          expMemData);
            checkOutput("alu_result_o", alu_result_o,        expAlu);
            checkOutput("writeReg_o",   32'(writeReg_o),     32'(expWriteReg));
            checkOutput("pc_o",         32'(pc_o),           32'(expPc));
            checkOutput("mem_to_reg_o", 32'(mem_to_reg_o),   32'(expMemToReg));
            checkOutput("reg_write_o",  32'(reg_write_o),    32'(expRegWrite));
            checkOutput("misalign_o",   32'(misalign_o),     32'(expMisalign));
`ifdef MEM_WB_DEBUG_PORT_EN
            checkOutput("debug_data_o", debug_data_o,        modelWord(32'(debug_addr_i)));
`endif
        end
    end

    function automatic logic [5:0] sigs(bit rd, bit wr, logic [1:0] sz, bit uns, bit m2r);
        return {rd, wr, sz, uns, m2r};
    endfunction

    // Drive one instruction and return just after the edge that captures it
    task automatic applyStimulus(input bit en, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [4:0] wreg, input logic [6:0] pc,
                                 input logic [5:0] ms, input bit rw);
        en_pipeline      = en;
        alu_result_i     = addr;
        data_wr_to_mem_i = data;
        writeReg_i       = wreg;
        pc_i             = pc;
        mem_signals_i    = ms;
        reg_write_i      = rw;
        @(posedge clock_i);
        #2;
    endtask

    initial begin
        logic [31:0] rAddr;
        logic [1:0]  rSize;
        checkEnable = 1'b1;
        reset_i = 1'b0;

        // Reset held with arbitrary inputs, stores included
        repeat (3) applyStimulus(1'b1, $urandom, $urandom, 5'($urandom), 7'($urandom), 6'($urandom), 1'b1);
        checkOutput("reset_mem_data", mem_data_o, 32'h0);
        checkOutput("reset_alu", alu_result_o, 32'h0);
        checkOutput("reset_misalign", 32'(misalign_o), 32'h0);
        reset_i = 1'b1;

        applyStimulus(1'b1, 32'h10, 32'h0, 5'd3, 7'd5, sigs(0, 0, 2'b11, 0, 0), 1'b1);
        checkOutput("first_alu", alu_result_o, 32'h10);
        checkOutput("first_pc", 32'(pc_o), 32'd5);
        checkOutput("first_wreg", 32'(writeReg_o), 32'd3);
        checkOutput("first_mem_data", mem_data_o, 32'h0);

        // Fill every word so nothing depends on the initial memory image
        for (int i = 0; i < 128; i++)
            applyStimulus(1'b1, 32'(i * 4), $urandom, 5'd1, 7'(i), sigs(0, 1, 2'b11, 0, 0), 1'b0);

        // Word store then load
        applyStimulus(1'b1, 32'h8, 32'hDEADBEEF, 5'd0, 7'd1, sigs(0, 1, 2'b11, 0, 0), 1'b0);
        applyStimulus(1'b1, 32'h8, 32'h0, 5'd4, 7'd2, sigs(1, 0, 2'b11, 0, 1), 1'b1);
        checkOutput("word_load", mem_data_o, 32'hDEADBEEF);
`ifdef MEM_WB_DEBUG_PORT_EN
        debug_addr_i = 7'd2;
        #1 checkOutput("debug_word2", debug_data_o, 32'hDEADBEEF);
`endif

        // Byte and half formatting
        applyStimulus(1'b1, 32'h9, 32'h0, 5'd4, 7'd3, sigs(1, 0, 2'b00, 0, 1), 1'b1);
        checkOutput("lb_signed", mem_data_o, 32'hFFFFFFBE);
        applyStimulus(1'b1, 32'h9, 32'h0, 5'd4, 7'd4, sigs(1, 0, 2'b00, 1, 1), 1'b1);
        checkOutput("lb_unsigned", mem_data_o, 32'h000000BE);
        applyStimulus(1'b1, 32'hA, 32'h0, 5'd4, 7'd5, sigs(1, 0, 2'b01, 0, 1), 1'b1);
        checkOutput("lh_signed", mem_data_o, 32'hFFFFDEAD);
        applyStimulus(1'b1, 32'hB, 32'h11, 5'd0, 7'd6, sigs(0, 1, 2'b00, 0, 0), 1'b0);
        applyStimulus(1'b1, 32'h8, 32'h0, 5'd4, 7'd7, sigs(1, 0, 2'b11, 0, 1), 1'b1);
        checkOutput("sb_then_lw", mem_data_o, 32'h11ADBEEF);

        // Misaligned word store is suppressed and sets the sticky flag
        applyStimulus(1'b1, 32'h6, 32'h12345678, 5'd9, 7'd8, sigs(0, 1, 2'b11, 0, 0), 1'b1);
        checkOutput("misalign_set", 32'(misalign_o), 32'h1);
        checkOutput("misalign_regwr", 32'(reg_write_o), 32'h0);
        applyStimulus(1'b1, 32'h4, 32'h0, 5'd4, 7'd9, sigs(1, 0, 2'b11, 0, 1), 1'b1);
        applyStimulus(1'b1, 32'h8, 32'h0, 5'd4, 7'd10, sigs(1, 0, 2'b11, 0, 1), 1'b1);
        checkOutput("misalign_sticky", 32'(misalign_o), 32'h1);
        checkOutput("misalign_aligned_regwr", 32'(reg_write_o), 32'h1);

        // Reset asserted mid-store: the store must not land
        alu_result_i = 32'h8; data_wr_to_mem_i = 32'hFFFFFFFF;
        mem_signals_i = sigs(0, 1, 2'b11, 0, 0); en_pipeline = 1'b1;
        #1 reset_i = 1'b0;
        @(posedge clock_i);
        #2 reset_i = 1'b1;
        checkOutput("reset_clears_flag", 32'(misalign_o), 32'h0);
        applyStimulus(1'b1, 32'h8, 32'h0, 5'd4, 7'd11, sigs(1, 0, 2'b11, 0, 1), 1'b1);
        checkOutput("reset_blocks_store", mem_data_o, 32'h11ADBEEF);

        // Stall blocks the store and holds outputs; enabling completes it
        applyStimulus(1'b0, 32'h20, 32'hCAFEF00D, 5'd7, 7'd12, sigs(0, 1, 2'b11, 0, 0), 1'b1);
        checkOutput("stall_hold_alu", alu_result_o, 32'h8);
        checkOutput("stall_hold_pc", 32'(pc_o), 32'd11);
        applyStimulus(1'b1, 32'h20, 32'h0, 5'd4, 7'd13, sigs(1, 0, 2'b11, 0, 1), 1'b1);
        applyStimulus(1'b1, 32'h20, 32'hCAFEF00D, 5'd0, 7'd14, sigs(0, 1, 2'b11, 0, 0), 1'b0);
        applyStimulus(1'b1, 32'h20, 32'h0, 5'd4, 7'd15, sigs(1, 0, 2'b11, 0, 1), 1'b1);
        checkOutput("stall_then_store", mem_data_o, 32'hCAFEF00D);

        // Address wrap and read/write conflict
        applyStimulus(1'b1, 32'h200, 32'h0BADF00D, 5'd0, 7'd16, sigs(0, 1, 2'b11, 0, 0), 1'b0);
        applyStimulus(1'b1, 32'h0, 32'h0, 5'd4, 7'd17, sigs(1, 0, 2'b11, 0, 1), 1'b1);
        checkOutput("wrap_load", mem_data_o, 32'h0BADF00D);
        applyStimulus(1'b1, 32'h10, 32'h55AA55AA, 5'd4, 7'd18, sigs(1, 1, 2'b11, 0, 1), 1'b1);
        checkOutput("conflict_data_zero", mem_data_o, 32'h0);
        applyStimulus(1'b1, 32'h10, 32'h0, 5'd4, 7'd19, sigs(1, 0, 2'b11, 0, 1), 1'b1);
        checkOutput("conflict_stored", mem_data_o, 32'h55AA55AA);

        // Randomized traffic with occasional stalls and asynchronous resets
        for (int n = 0; n < 2000; n++) begin
            rSize = 2'($urandom);
            rAddr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) begin
                if (rSize == 2'b01) rAddr[0] = 1'b0;
                else if (rSize != 2'b00) rAddr[1:0] = 2'b00;
            end
`ifdef MEM_WB_DEBUG_PORT_EN
            debug_addr_i = 7'($urandom);
`endif
            applyStimulus($urandom_range(0, 9) != 0, rAddr, $urandom, 5'($urandom), 7'($urandom),
                          {2'($urandom), rSize, 2'($urandom)}, 1'($urandom));
            if ($urandom_range(0, 149) == 0) begin
                #1 reset_i = 1'b0;
                @(posedge clock_i);
                #2 reset_i = 1'b1;
            end
        end

        checkEnable = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register.
- Consumes the EX/MEM register outputs: ALU result as address, store data, destination register, PC and memory control bits.
- Performs byte/half/word loads and stores against an internal data memory, formats load data, and registers everything toward write-back.
- A debug read port exposes memory words to the debug unit while the pipeline is stalled.

Parameters:
- NB_DATA, 32, data/address width
- NB_REGWR, 5, destination register index width
- NB_PC, 7, PC width
- NB_MEM_ADDR, 7, log2 of data memory depth in 32-bit words (128 words)

Ports:
- clock_i  in  1  single clock; all state updates on rising edge
- reset_i  in  1  asynchronous, active-low reset
- en_pipeline  in  1  stage enable; 0 freezes the MEM/WB register and blocks stores
- alu_result_i  in  NB_DATA  byte address / pass-through result
- data_wr_to_mem_i  in  NB_DATA  store data, right-aligned
- writeReg_i  in  NB_REGWR  destination register
- pc_i  in  NB_PC  instruction PC
- mem_signals_i  in  6  [5] mem_read, [4] mem_write, [3:2] size (00 byte, 01 half, 11 word, 10 reserved = word), [1] unsigned load, [0] mem_to_reg
- reg_write_i  in  1  write-back enable
- debug_addr_i  in  NB_MEM_ADDR  debug word index
- mem_data_o  out  NB_DATA  registered formatted load data
- alu_result_o  out  NB_DATA  registered ALU result
- writeReg_o  out  NB_REGWR  registered destination
- pc_o  out  NB_PC  registered PC
- mem_to_reg_o  out  1  registered mem_signals_i[0]
- reg_write_o  out  1  registered write-back enable
- misalign_o  out  1  sticky misaligned-access flag
- debug_data_o  out  NB_DATA  combinational memory word at debug_addr_i

Behaviour:
- Reset (reset_i=0, asynchronous):
  - all registered outputs go to 0, including misalign_o.
  - Memory contents are not cleared; memory is zero-initialised at configuration.
- Addressing:
  - word index = alu_result_i[NB_MEM_ADDR+1:2]; byte lane = alu_result_i[1:0].
  - Upper address bits are ignored, so addresses wrap modulo the memory size.
- Alignment:
  - byte accesses are always aligned.
  - A half access is misaligned if addr[0]=1.
  - A word access is misaligned if addr[1:0]≠0.
- Store (mem_write=1, aligned, en_pipeline=1):
  - byte-enable write on the rising edge.
  - byte: lane addr[1:0] gets data[7:0].
  - half: lanes {addr[1],0}+1:{addr[1],0} get data[15:0].
  - word: all lanes.
  - Other lanes are unchanged.
- Load (mem_read=1, mem_write=0, aligned):
  - combinational read of the word, then select the lane(s).
  - Sign-extend unless the unsigned bit is 1, in which case zero-extend.
  - Result is registered into mem_data_o.
- Load latency:
  - mem_data_o is valid one cycle after the instruction is presented.
  - A store at cycle N is visible to a load presented at cycle N+1 (read-after-write, no hazard).
- mem_read and mem_write both 1: treated as a store only; mem_data_o loads 0.
- Neither read nor write: mem_data_o loads 0.
- Misaligned access:
  - the store is suppressed and load data is 0.
  - reg_write_o is registered as 0 for that instruction.
  - misalign_o sets on the edge and stays 1 until reset.
- en_pipeline=0: every register holds its value, no store occurs, and misalign_o does not update.
- debug_data_o is always driven, independent of en_pipeline.
- If reset asserts mid-store, no partial write completes after the reset edge, and the array keeps its prior contents.

Optional Feature:
- Macro MEM_WB_DEBUG_PORT_EN.
- Defined: the debug_addr_i and debug_data_o ports exist, with behaviour as above.
- Undefined: both ports are removed and the memory has a single read port.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: hold reset_i=0 with arbitrary inputs -> all outputs 0 and misalign_o=0. Release reset, then drive en_pipeline=1 with alu_result_i=0x10, pc_i=5, writeReg_i=3 and no memory operation -> next cycle alu_result_o=0x10, pc_o=5, writeReg_o=3, mem_data_o=0.
- Word store/load: store 0xDEADBEEF at addr 0x8, then load word at 0x8 on the next cycle -> mem_data_o=0xDEADBEEF one cycle later; debug_addr_i=2 gives debug_data_o=0xDEADBEEF.
- Byte/half formatting: after the store above, load byte signed at 0x9 -> 0xFFFFFFBE; byte unsigned at 0x9 -> 0x000000BE; half signed at 0xA -> 0xFFFFDEAD. Store byte 0x11 at 0xB -> word reads 0x11ADBEEF.
- Misalignment: word store of 0x12345678 at 0x6 -> memory unchanged, misalign_o=1 next cycle, reg_write_o=0. The flag stays 1 through later aligned accesses until reset_i pulses low.
- Stall: en_pipeline=0 with a word store of 0xCAFEF00D at 0x20 -> memory word 8 unchanged, outputs hold. Set en_pipeline=1 -> store completes and a following load returns 0xCAFEF00D.
- Wrap and conflict:
  - word store at 0x200, with NB_MEM_ADDR=7 -> lands in word 0 and is readable at addr 0x0.
  - mem_read=1 with mem_write=1 -> store occurs and mem_data_o=0.
